seg_display_scheduler: RTL
==========================

// Module: seg_display_scheduler
// PURPOSE
//  Sequences a multiplexed NDIG-digit 7-segment display from two raw push keys.
//  Each key is synchronised and debounced; key_a presses increment, key_b presses decrement a hex counter.
//  A free-running scan scheduler time-shares one segment bus across NDIG digits.
//  Sits between board keys and display pins; replaces single-digit combinational indicator control.
// PARAMETERS
//  NDIG       4    number of digits (2..8); counter width = 4*NDIG
//  DEB_CYCLES 16   consecutive stable samples required to accept a key level change (>=2)
//  SCAN_DIV   1024 clock cycles each digit stays selected (>=2)
// PORTS
//  clk    in   1       system clock, rising edge
//  rst_n  in   1       asynchronous active-low reset
//  key_a  in   1       raw key, active high, asynchronous; press = increment
//  key_b  in   1       raw key, active high, asynchronous; press = decrement
//  seg    out  7       segments {g,f,e,d,c,b,a}, active high, seg[0]=a
//  an     out  NDIG    digit enable, one-hot, active high, an[0]=least significant digit
//  value  out  4*NDIG  current counter value
// BEHAVIOUR
//  Reset (async assert, sync release): value=0, scan index=0, an=1, seg=7'h3F, prescaler=0,
//   sync flops, debounced levels and debounce counters=0.
//  Key path, per key: 2-FF synchroniser -> debouncer -> rising-edge detect.
//   Debouncer: counter clears when synced level == debounced level; otherwise increments;
//   when it reaches DEB_CYCLES-1 debounced level toggles and counter clears.
//   Glitch shorter than DEB_CYCLES samples: no level change, no event.
//   Press event = one-cycle pulse on debounced 0->1; release produces no event.
//   Latency: raw key high, first sampled at edge t, stays high -> value updates at edge t+DEB_CYCLES+3.
//   Holding a key: exactly one event (no auto-repeat).
//   Key held high through reset release: counts as press once debounced.
//  Counter: inc event -> value+1; dec event -> value-1; modulo 2^(4*NDIG) wrap both ways
//   (all-F +1 -> 0; 0 -1 -> all-F). inc and dec events in same cycle -> value unchanged.
//  Scan scheduler: prescaler counts 0..SCAN_DIV-1; at SCAN_DIV-1 wraps to 0 and index
//   advances 0..NDIG-1 then wraps to 0. an = one-hot(index), registered.
//  seg = registered hex decode of nibble value[4*index+:4], updated every cycle, so a value
//   change is visible on seg one cycle later without waiting for a scan step.
//   Codes 0-F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
//  an and seg are produced in the same cycle: never a cycle with new an and stale-digit seg.
//  Reset mid-scan or mid-debounce: all state returns to reset values immediately.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined: digit i>0 shows seg=0 when all nibbles i..NDIG-1 are zero;
//   digit 0 always shown (value 0 -> "   0"). an keeps scanning unchanged.
//  Not defined: every digit always shows its hex code (value 0 -> "0000").
// STRUCTURE
//  Package seg_display_pkg: SEG_HEX[16] 7-bit pattern table, SEG_BLANK=7'h00, and a
//   seg_hex function returning the pattern for one nibble.
//  Sub-module key_debounce (params DEB_CYCLES): sync + debounce + press pulse; instanced twice.
//  Top holds counter, prescaler, scan index, decode and output registers.
// TESTING (NDIG=4, DEB_CYCLES=4, SCAN_DIV=8)
//  Reset: rst_n low -> value=0, an=4'b0001, seg=7'h3F; release -> an steps 0001,0010,0100,1000,0001, 8 cycles each.
//  key_a high 20 cycles from edge t -> value=1 at edge t+7, unchanged for the rest of the hold; release -> no change.
//  key_a pulse 3 cycles -> value unchanged; key_b press at value=0 -> 16'hFFFF, digit seg all 7'h71.
//  key_a and key_b raised on same edge and held -> value unchanged; then 16'hFFFF +1 -> 16'h0000.
//  value=16'h0A05 with LEADING_ZERO_BLANK_EN -> digit3 seg=00, digit2 77, digit1 3F, digit0 6D; without -> digit3 3F.
//  rst_n asserted mid-debounce (key_a high 2 cycles) and mid-scan (an=0100) -> all outputs at reset values at once, no event after release until key re-debounced.

Source files
------------

// File: rtl/seg_display_pkg.sv
// Shared 7-segment pattern table and nibble decode for the display scheduler.
// Segment order is {g,f,e,d,c,b,a}, active high.
package seg_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_hex(input logic [3:0] nib);
        return SEG_HEX[nib];
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw key front end: 2-FF synchroniser, stability-count debouncer and a
// one-cycle registered pulse on each accepted 0->1 level change.
module key_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= key_raw;
            sync2   <= sync1;
            level_d <= level;
            press   <= level & ~level_d;
            // Any sample matching the accepted level restarts the stability window.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// Two-key hex up/down counter driving a multiplexed NDIG-digit 7-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg_display_scheduler
    import seg_display_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int DEB_CYCLES = 16,
    parameter int SCAN_DIV   = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_a,
    input  logic              key_b,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   an,
    output logic [4*NDIG-1:0] value
);

    localparam int VW = 4 * NDIG;
    localparam int IW = (NDIG > 2) ? $clog2(NDIG) : 1;
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    localparam logic [IW-1:0]   IDX_MAX = IW'(NDIG - 1);
    localparam logic [PW-1:0]   PS_MAX  = PW'(SCAN_DIV - 1);
    localparam logic [NDIG-1:0] AN_ONE  = {{(NDIG-1){1'b0}}, 1'b1};

    logic          inc;
    logic          dec;
    logic [PW-1:0] prescale;
    logic [IW-1:0] idx;
    logic          blank;
    logic [6:0]    seg_next;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_raw (key_a),
        .press   (inc)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_raw (key_b),
        .press   (dec)
    );

    // Decode follows the live value so a count change shows up without waiting for a scan step.
    always_comb begin
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blank = (idx != '0) && ((value >> {idx, 2'b00}) == '0);
`endif
        seg_next = blank ? SEG_BLANK : seg_hex(value[{idx, 2'b00} +: 4]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value    <= '0;
            prescale <= '0;
            idx      <= '0;
            an       <= AN_ONE;
            seg      <= seg_hex(4'h0);
        end else begin
            if (inc && !dec) begin
                value <= value + VW'(1);
            end else if (dec && !inc) begin
                value <= value - VW'(1);
            end

            if (prescale == PS_MAX) begin
                prescale <= '0;
                idx      <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
            end else begin
                prescale <= prescale + PW'(1);
            end

            // an and seg both derive from the same idx so they always change together.
            an  <= AN_ONE << idx;
            seg <= seg_next;
        end
    end

endmodule
